// File: rtl/instruction_rom.sv
// Instruction ROM with a byte-serial image loader and a combinational fetch port.
// Define ROM_LOAD_CHECKSUM_EN to add a running sum of the words written by the current load.
module instruction_rom #(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  chip_enable,
   input  logic [31:0]           address,
   output logic [31:0]           data,
   input  logic                  load_start,
   input  logic                  load_valid,
   input  logic [7:0]            load_byte,
   input  logic                  load_last,
   output logic                  load_ready,
   output logic                  load_done,
   output logic [DEPTH_LOG2:0]   load_count,
   output logic [31:0]           checksum
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   localparam int unsigned          WORDS = 2**DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]  FULL  = (DEPTH_LOG2+1)'(WORDS);

   state_t              state;
   logic [31:0]         mem [WORDS];
   logic [1:0]          byte_idx;
   logic [23:0]         partial;
   logic                accept;
   logic                wr_en;
   logic [31:0]         wr_word;
   logic [DEPTH_LOG2:0] count_inc;
   logic                in_range;
   logic                unused_addr_bits;

   // load_start wins over a byte offered in the same cycle
   assign accept    = (state == LOAD) && load_valid && !load_start;
   assign wr_en     = accept && ((byte_idx == 2'd3) || load_last);
   assign count_inc = load_count + 1'b1;

   // Current byte lands in its big-endian lane; unfilled low lanes stay zero.
   always_comb begin
      wr_word = '0;
      case (byte_idx)
         2'd0:    wr_word = {load_byte, 24'h0};
         2'd1:    wr_word = {partial[23:16], load_byte, 16'h0};
         2'd2:    wr_word = {partial[23:8], load_byte, 8'h0};
         default: wr_word = {partial, load_byte};
      endcase
   end

   // load_count doubles as the write pointer: both clear together and step on every write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         load_count <= '0;
         byte_idx   <= '0;
         partial    <= '0;
         load_ready <= 1'b0;
         load_done  <= 1'b0;
      end else if (load_start) begin
         state      <= LOAD;
         load_count <= '0;
         byte_idx   <= '0;
         partial    <= '0;
         load_ready <= 1'b1;
         load_done  <= 1'b0;
      end else if (accept) begin
         if (wr_en) begin
            load_count <= count_inc;
            byte_idx   <= '0;
            partial    <= '0;
            if (load_last || (count_inc == FULL)) begin
               state      <= DONE;
               load_ready <= 1'b0;
               load_done  <= 1'b1;
            end
         end else begin
            case (byte_idx)
               2'd0:    partial[23:16] <= load_byte;
               2'd1:    partial[15:8]  <= load_byte;
               default: partial[7:0]   <= load_byte;
            endcase
            byte_idx <= byte_idx + 2'd1;
         end
      end
   end

   // Storage deliberately has no reset so an image survives a reset.
   always_ff @(posedge clock) begin
      if (wr_en) mem[load_count[DEPTH_LOG2-1:0]] <= wr_word;
   end

`ifdef ROM_LOAD_CHECKSUM_EN
   logic [31:0] sum_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)           sum_q <= '0;
      else if (load_start) sum_q <= '0;
      else if (wr_en)      sum_q <= sum_q + wr_word;
   end

   assign checksum = sum_q;
`else
   assign checksum = '0;
`endif

   assign in_range         = (address[31:DEPTH_LOG2+2] == '0);
   assign unused_addr_bits = ^address[1:0];
   assign data = (chip_enable && (state != LOAD) && in_range) ?
                 mem[address[DEPTH_LOG2+1:2]] : '0;

endmodule

// File: tb/tb_instruction_rom.sv
// Bench for instruction_rom: two instances (depth 1024 and depth 4) share one stimulus stream
// and are checked every cycle against a byte-queue model plus literal expectations.
module tb_instruction_rom;

   logic        clock = 1'b0;
   logic        reset;
   logic        chip_enable;
   logic [31:0] address;
   logic        load_start;
   logic        load_valid;
   logic [7:0]  load_byte;
   logic        load_last;

   logic [31:0] a_data, a_csum, b_data, b_csum;
   logic        a_ready, a_done, b_ready, b_done;
   logic [10:0] a_count;
   logic [2:0]  b_count;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   instruction_rom #(.DEPTH_LOG2(10)) dut_a (
      .clock(clock), .reset(reset), .chip_enable(chip_enable), .address(address), .data(a_data),
      .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
      .load_ready(a_ready), .load_done(a_done), .load_count(a_count), .checksum(a_csum));

   instruction_rom #(.DEPTH_LOG2(2)) dut_b (
      .clock(clock), .reset(reset), .chip_enable(chip_enable), .address(address), .data(b_data),
      .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte), .load_last(load_last),
      .load_ready(b_ready), .load_done(b_done), .load_count(b_count), .checksum(b_csum));

   always #5 clock = ~clock;

   // ---------------- behavioural model ----------------
   localparam int M_IDLE = 0, M_LOAD = 1, M_DONE = 2;
   int          m_state [2];
   int          m_cnt   [2];
   logic [31:0] m_sum   [2];
   int          m_nb    [2];
   logic [7:0]  m_buf   [2][4];
   logic [31:0] m_mem   [2][1024];
   bit          m_known [2][1024];

   function automatic int depth(input int k);
      return (k == 0) ? 10 : 2;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_state[k] = M_IDLE; m_cnt[k] = 0; m_sum[k] = 0; m_nb[k] = 0;
      end
   endtask

   task automatic model_step();
      logic [31:0] word;
      if (reset) return;
      for (int k = 0; k < 2; k++) begin
         if (load_start) begin
            m_state[k] = M_LOAD; m_cnt[k] = 0; m_sum[k] = 0; m_nb[k] = 0;
         end else if (m_state[k] == M_LOAD && load_valid) begin
            m_buf[k][m_nb[k]] = load_byte;
            m_nb[k]++;
            if (m_nb[k] == 4 || load_last) begin
               word = 0;
               for (int i = 0; i < m_nb[k]; i++) word[31-8*i -: 8] = m_buf[k][i];
               m_mem[k][m_cnt[k]]   = word;
               m_known[k][m_cnt[k]] = 1'b1;
               m_cnt[k]++;
               m_sum[k] += word;
               m_nb[k] = 0;
               if (load_last || m_cnt[k] == (1 << depth(k))) m_state[k] = M_DONE;
            end
         end
      end
   endtask

   function automatic bit exp_data(input int k, output logic [31:0] v);
      int idx;
      v = 0;
      if (!chip_enable || m_state[k] == M_LOAD || (address >> (depth(k) + 2)) != 0) return 1'b1;
      idx = int'((address >> 2) & ((32'd1 << depth(k)) - 1));
      if (!m_known[k][idx]) return 1'b0;
      v = m_mem[k][idx];
      return 1'b1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, exp);
      end
   endtask

   task automatic check_dut(input int k, input logic r, input logic d, input logic [31:0] cnt,
                            input logic [31:0] cs, input logic [31:0] dt);
      logic [31:0] ev;
      string p;
      p = (k == 0) ? "a" : "b";
      chk({p, ".load_ready"}, {31'b0, r}, {31'b0, m_state[k] == M_LOAD});
      chk({p, ".load_done"},  {31'b0, d}, {31'b0, m_state[k] == M_DONE});
      chk({p, ".load_count"}, cnt, m_cnt[k]);
`ifdef ROM_LOAD_CHECKSUM_EN
      chk({p, ".checksum"}, cs, m_sum[k]);
`else
      chk({p, ".checksum"}, cs, 32'h0);
`endif
      if (exp_data(k, ev)) chk({p, ".data"}, dt, ev);
   endtask

   always @(negedge clock) begin
      if (cmp_en) begin
         check_dut(0, a_ready, a_done, 32'(a_count), a_csum, a_data);
         check_dut(1, b_ready, b_done, 32'(b_count), b_csum, b_data);
      end
   end

   // ---------------- stimulus ----------------
   task automatic cyc();
      @(posedge clock);
      model_step();
      #1;
   endtask

   task automatic send(input logic [7:0] b, input logic last);
      load_valid = 1'b1; load_byte = b; load_last = last;
      cyc();
      load_valid = 1'b0; load_last = 1'b0;
   endtask

   task automatic settle();
      @(negedge clock);
      #1;
   endtask

   logic [7:0] img1 [8];

   initial begin
      img1 = '{8'h3C, 8'h01, 8'h12, 8'h34, 8'h34, 8'h21, 8'h56, 8'h78};
      reset = 1'b1; chip_enable = 1'b0; address = 0;
      load_start = 1'b0; load_valid = 1'b0; load_byte = 0; load_last = 1'b0;
      model_reset();
      #2;
      settle();
      chk("reset_ready", {31'b0, a_ready}, 32'h0);
      chk("reset_done",  {31'b0, a_done},  32'h0);
      chk("reset_count", 32'(a_count), 32'h0);
      chk("reset_csum",  a_csum, 32'h0);
      cmp_en = 1'b1;
      cyc();
      reset = 1'b0;
      cyc();

      // two-word image, last byte on the eighth
      chip_enable = 1'b1; address = 0;
      load_start = 1'b1; cyc(); load_start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         send(img1[i], i == 7);
         if (i == 1) begin
            settle();
            chk("data_during_load", a_data, 32'h0);
         end
      end
      settle();
      chk("img1_done",  {31'b0, a_done}, 32'h1);
      chk("img1_count", 32'(a_count), 32'd2);
      chk("img1_word0", a_data, 32'h3C011234);
      address = 32'h7; #1;
      chk("img1_word1", a_data, 32'h34215678);
`ifdef ROM_LOAD_CHECKSUM_EN
      chk("img1_csum", a_csum, 32'h702268AC);
`else
      chk("img1_csum", a_csum, 32'h0);
`endif
      chk("img1_b_count", 32'(b_count), 32'd2);
      for (int i = 0; i < 6; i++) begin
         case (i)
            0: address = 32'h1;
            1: address = 32'h6;
            2: address = 32'h10;
            3: address = 32'h1000;
            4: address = 32'h8000_0000;
            default: address = 32'h0;
         endcase
         cyc();
      end

      // short image padded with zeros
      load_start = 1'b1; cyc(); load_start = 1'b0;
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      settle();
      chk("pad_word0", a_data, 32'hAABB0000);
      chk("pad_count", 32'(a_count), 32'd1);
      chk("pad_done",  {31'b0, a_done}, 32'h1);
      address = 32'h4; #1;
      chk("pad_word1_kept", a_data, 32'h34215678);

      // overflow of the depth-4 instance
      load_start = 1'b1; cyc(); load_start = 1'b0;
      for (int i = 0; i < 20; i++) send(8'(i + 1), 1'b0);
      settle();
      chk("full_b_count", 32'(b_count), 32'd4);
      chk("full_b_ready", {31'b0, b_ready}, 32'h0);
      chk("full_b_done",  {31'b0, b_done}, 32'h1);
      address = 32'h10; #1;
      chk("full_b_oob",   b_data, 32'h0);
      chk("full_a_count", 32'(a_count), 32'd5);
      address = 32'hC; #1;
      chk("full_b_word3", b_data, 32'h0D0E0F10);
      cyc();

      // reset in the middle of a load
      address = 0;
      load_start = 1'b1; cyc(); load_start = 1'b0;
      for (int i = 0; i < 6; i++) send(8'(8'hC0 + i), 1'b0);
      reset = 1'b1; model_reset(); #1;
      chk("abort_count", 32'(a_count), 32'h0);
      chk("abort_ready", {31'b0, a_ready}, 32'h0);
      chk("abort_done",  {31'b0, a_done}, 32'h0);
      cyc();
      reset = 1'b0;
      settle();
      chk("abort_word0", a_data, 32'hC0C1C2C3);
      address = 32'h4; #1;
      chk("abort_word1", a_data, 32'h05060708);
      cyc();

      // restart while a byte is offered
      address = 0;
      load_start = 1'b1; cyc(); load_start = 1'b0;
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      load_start = 1'b1; load_valid = 1'b1; load_byte = 8'hEE;
      cyc();
      load_start = 1'b0; load_valid = 1'b0;
      settle();
      chk("restart_count", 32'(a_count), 32'h0);
      chk("restart_ready", {31'b0, a_ready}, 32'h1);
      send(8'h33, 1'b0);
      send(8'h44, 1'b0);
      send(8'h55, 1'b0);
      send(8'h66, 1'b1);
      settle();
      chk("restart_word0", a_data, 32'h33445566);
      chk("restart_cnt1",  32'(a_count), 32'd1);

      // fetch disabled in DONE
      chip_enable = 1'b0;
      cyc();
      settle();
      chk("ce_off_data", a_data, 32'h0);
      chk("ce_off_done", {31'b0, a_done}, 32'h1);
      cyc();
      cmp_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
